adc0832_scheduler: RTL

- Sequences complete ADC0832 serial transactions.
- Generates CS_n, SCLK and DI (start, SGL/DIF, ODD/SIGN).
- Shifts in the MSB-first byte, then the LSB-first echo, and cross-checks the two.
- Sits between the sensor-acquisition logic and the ADC pins. Serves one fixed channel or alternates CH0/CH1 round-robin, in single-shot or continuous mode.

---
 rtl/adc0832_pkg.sv | 34 +++
 rtl/adc0832_scheduler_if.sv | 30 +++
 rtl/adc_sclk_gen.sv | 43 ++++
 rtl/adc0832_scheduler.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/adc0832_pkg.sv
// Shared types and constants for the ADC0832 transaction scheduler.
package adc0832_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_GAP
    } state_t;

    localparam int MUX_BITS       = 3;
    localparam int SETTLE_PERIODS = 1;
    localparam int DATA_BITS      = 8;
    localparam int ECHO_BITS      = 7;
    localparam int TOTAL_PERIODS  = 19;

    // First SCLK period carrying the MSB, and first carrying the echo bit B1.
    localparam int FIRST_DATA_PERIOD = MUX_BITS + SETTLE_PERIODS + 1;
    localparam int FIRST_ECHO_PERIOD = FIRST_DATA_PERIOD + DATA_BITS;

    localparam logic START_BIT = 1'b1;
    localparam logic SGL_BIT   = 1'b1;

    // Value of DI during a given SCLK period: start, SGL/DIF, ODD/SIGN, then idle low.
    function automatic logic di_for_period(input logic [4:0] period, input logic channel);
        case (period)
            5'd1:    return START_BIT;
            5'd2:    return SGL_BIT;
            5'd3:    return channel;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/adc0832_scheduler_if.sv
// Bundle between the acquisition logic / ADC pins and the scheduler.
interface adc0832_scheduler_if;
    import adc0832_pkg::*;

    logic                 enable;
    logic                 continuous;
    logic                 start;
    logic                 scan_en;
    logic                 channel_sel;
    logic                 adc_do;
    logic                 adc_cs_n;
    logic                 adc_sclk;
    logic                 adc_di;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_channel;
    logic                 data_valid;
    logic                 data_error;
    logic                 busy;

    modport master (
        output enable, continuous, start, scan_en, channel_sel, adc_do,
        input  adc_cs_n, adc_sclk, adc_di, data_out, data_channel, data_valid, data_error, busy
    );

    modport slave (
        input  enable, continuous, start, scan_en, channel_sel, adc_do,
        output adc_cs_n, adc_sclk, adc_di, data_out, data_channel, data_valid, data_error, busy
    );

endinterface

// File: rtl/adc_sclk_gen.sv
// SCLK generator: half-period counter with strobes marking the clk where SCLK toggles.
module adc_sclk_gen #(
    parameter int HALF_DIV = 125
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    input  logic hold_low,
    output logic sclk,
    output logic half_tick,
    output logic rise_tick,
    output logic fall_tick
);

    localparam logic [7:0] HALF_LAST = 8'(HALF_DIV - 1);

    logic [7:0] count;

    assign half_tick = run && (count == HALF_LAST);
    assign rise_tick = half_tick && !hold_low && !sclk;
    assign fall_tick = half_tick && sclk;

    // Count half-periods and flip SCLK at each boundary unless held low.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
            sclk  <= 1'b0;
        end else if (run) begin
            if (half_tick) begin
                count <= '0;
            end else begin
                count <= count + 8'd1;
            end
            if (rise_tick) begin
                sclk <= 1'b1;
            end else if (fall_tick) begin
                sclk <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/adc0832_scheduler.sv
// Sequences complete ADC0832 conversions: mux addressing, MSB-first byte, LSB-first echo check.
module adc0832_scheduler
    import adc0832_pkg::*;
#(
    parameter int HALF_DIV = 125,
    parameter int CS_GAP   = 50
) (
    input logic clk,
    input logic rst,
    adc0832_scheduler_if.slave bus
);

    localparam logic [4:0] LAST_PERIOD = 5'(TOTAL_PERIODS);
    localparam logic [4:0] DATA_FIRST  = 5'(FIRST_DATA_PERIOD);
    localparam logic [4:0] DATA_LAST   = 5'(FIRST_ECHO_PERIOD - 1);
    localparam logic [4:0] ECHO_FIRST  = 5'(FIRST_ECHO_PERIOD);
    localparam logic [7:0] GAP_LAST    = 8'(CS_GAP - 1);

    state_t                 state, state_next;
    logic                   launch, finish, gap_done;
    logic                   sclk_run, sclk_clear, sclk;
    logic                   half_tick, rise_tick, fall_tick;
    logic [4:0]             period;
    logic [7:0]             gap_count;
    logic                   channel, scan_ptr;
    logic [DATA_BITS-1:0]   msb_byte;
    logic [ECHO_BITS-1:0]   lsb_bits;
    logic                   cs_n, di, busy;
    logic [DATA_BITS-1:0]   data_out;
    logic                   data_channel, data_valid, data_error;

    assign sclk_run   = (state == ST_SETUP) || (state == ST_SHIFT);
    assign sclk_clear = launch || !bus.enable;
    assign gap_done   = (state == ST_GAP) && (gap_count == GAP_LAST);

    assign bus.adc_cs_n     = cs_n;
    assign bus.adc_sclk     = sclk;
    assign bus.adc_di       = di;
    assign bus.busy         = busy;
    assign bus.data_out     = data_out;
    assign bus.data_channel = data_channel;
    assign bus.data_valid   = data_valid;
    assign bus.data_error   = data_error;

    adc_sclk_gen #(.HALF_DIV(HALF_DIV)) sclk_gen (
        .clk       (clk),
        .rst       (rst),
        .run       (sclk_run),
        .clear     (sclk_clear),
        .hold_low  (state == ST_SETUP),
        .sclk      (sclk),
        .half_tick (half_tick),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus launch/finish strobes; a continuous GAP end relaunches with no idle clk.
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        finish     = 1'b0;
        if (!bus.enable) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.continuous || bus.start) begin
                        launch     = 1'b1;
                        state_next = ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (half_tick) begin
                        state_next = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (fall_tick && (period == LAST_PERIOD)) begin
                        finish     = 1'b1;
                        state_next = ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_done) begin
                        if (bus.continuous) begin
                            launch     = 1'b1;
                            state_next = ST_SETUP;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Pin drive, bit capture, result publication and scan pointer; enable low aborts cleanly.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_n         <= 1'b1;
            di           <= 1'b0;
            busy         <= 1'b0;
            period       <= '0;
            gap_count    <= '0;
            channel      <= 1'b0;
            scan_ptr     <= 1'b0;
            msb_byte     <= '0;
            lsb_bits     <= '0;
            data_out     <= '0;
            data_channel <= 1'b0;
            data_valid   <= 1'b0;
            data_error   <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (!bus.enable) begin
                cs_n     <= 1'b1;
                di       <= 1'b0;
                busy     <= 1'b0;
                scan_ptr <= 1'b0;
            end else begin
                if (launch) begin
                    channel <= bus.scan_en ? scan_ptr : bus.channel_sel;
                    cs_n    <= 1'b0;
                    di      <= START_BIT;
                    busy    <= 1'b1;
                    period  <= 5'd1;
                end
                if ((state == ST_SHIFT) && rise_tick) begin
                    if ((period >= DATA_FIRST) && (period <= DATA_LAST)) begin
                        msb_byte <= {msb_byte[DATA_BITS-2:0], bus.adc_do};
                    end else if (period >= ECHO_FIRST) begin
                        lsb_bits <= {bus.adc_do, lsb_bits[ECHO_BITS-1:1]};
                    end
                end
                if ((state == ST_SHIFT) && fall_tick) begin
                    if (finish) begin
                        cs_n         <= 1'b1;
                        di           <= 1'b0;
                        gap_count    <= '0;
                        data_out     <= msb_byte;
                        data_channel <= channel;
                        data_error   <= (lsb_bits != msb_byte[DATA_BITS-1:1]);
                        data_valid   <= 1'b1;
                        if (bus.scan_en) begin
                            scan_ptr <= ~scan_ptr;
                        end
                    end else begin
                        period <= period + 5'd1;
                        di     <= di_for_period(period + 5'd1, channel);
                    end
                end
                if ((state == ST_GAP) && !gap_done) begin
                    gap_count <= gap_count + 8'd1;
                end
                if (gap_done && !launch) begin
                    busy <= 1'b0;
                end
            end
        end
    end

endmodule
